// File: rtl/pio_pkg.sv
// Shared PIO definitions: command action codes, machine count and the drain FSM states.
package pio_pkg;

  localparam int unsigned NUM_SM = 4;
  localparam int unsigned SM_W   = $clog2(NUM_SM);

  localparam logic [5:0] ACT_NONE      = 6'd0;
  localparam logic [5:0] ACT_LOAD_PROG = 6'd1;
  localparam logic [5:0] ACT_PULL_RX   = 6'd4;
  localparam logic [5:0] ACT_EXEC      = 6'd9;

  typedef enum logic [2:0] {
    SCAN  = 3'd0,
    REQ   = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    SEND  = 3'd4
  } state_e;

  // Machine index `off` positions after `base`, wrapping around NUM_SM.
  function automatic logic [SM_W-1:0] wrap_idx(input logic [SM_W-1:0] base,
                                               input int unsigned     off);
    int unsigned sum;
    sum = 32'(base) + off;
    return SM_W'(sum % NUM_SM);
  endfunction

endpackage

// File: rtl/uart_tx_8n1.sv
// 8N1 UART transmitter with a byte valid/ready handshake; a byte offered during the
// last stop-bit cycle is taken immediately so consecutive bytes leave with no idle gap.
module uart_tx_8n1 #(
  parameter int unsigned CLKS_PER_BIT = 217
) (
  input  logic       clk,
  input  logic       n_reset,
  input  logic       valid,
  input  logic [7:0] data,
  output logic       ready,
  output logic       tx
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);

  logic             active_q, active_d;
  logic             tx_q, tx_d;
  logic [7:0]       data_q, data_d;
  logic [3:0]       bit_q, bit_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bit_end_s;
  logic             last_s;

  assign bit_end_s = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
  assign last_s    = active_q && (bit_q == 4'd9) && bit_end_s;
  assign ready     = !active_q || last_s;
  assign tx        = tx_q;

  // bit_q: 0 = start, 1..8 = data bits 0..7, 9 = stop.
  always_comb begin
    active_d = active_q;
    tx_d     = tx_q;
    data_d   = data_q;
    bit_d    = bit_q;
    cnt_d    = cnt_q;
    if (valid && ready) begin
      active_d = 1'b1;
      tx_d     = 1'b0;
      data_d   = data;
      bit_d    = 4'd0;
      cnt_d    = CNT_W'(0);
    end else if (active_q) begin
      if (bit_end_s) begin
        cnt_d = CNT_W'(0);
        if (bit_q == 4'd9) begin
          active_d = 1'b0;
          tx_d     = 1'b1;
        end else begin
          bit_d = bit_q + 4'd1;
          tx_d  = (bit_q == 4'd8) ? 1'b1 : data_q[bit_q[2:0]];
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      tx_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      active_q <= 1'b0;
      tx_q     <= 1'b1;
      data_q   <= 8'h00;
      bit_q    <= 4'd0;
      cnt_q    <= CNT_W'(0);
    end else begin
      active_q <= active_d;
      tx_q     <= tx_d;
      data_q   <= data_d;
      bit_q    <= bit_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/pio_rx_uart.sv
// Drains PIO RX FIFOs round-robin over the shared command bus and streams each word
// out LSB byte first as 8N1 UART. Define PIO_RX_UART_TAG_EN to prefix a machine tag byte.
module pio_rx_uart
  import pio_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 217,
  parameter int unsigned READ_LATENCY = 1,
  parameter logic [5:0]  PULL_ACTION  = ACT_PULL_RX
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic [NUM_SM-1:0] rx_empty,
  input  logic [31:0]       dout,
  input  logic              bus_gnt,
  output logic              bus_req,
  output logic [5:0]        action,
  output logic [SM_W-1:0]   mindex,
  output logic              tx,
  output logic              busy
);

`ifdef PIO_RX_UART_TAG_EN
  localparam int unsigned NBYTES = 5;
`else
  localparam int unsigned NBYTES = 4;
`endif
  localparam int unsigned BC_W  = $clog2(NBYTES + 1);
  localparam int unsigned LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  state_e            state_q, state_d;
  logic [SM_W-1:0]   ptr_q, ptr_d;
  logic [SM_W-1:0]   mindex_q, mindex_d;
  logic              bus_req_q, bus_req_d;
  logic [5:0]        action_q, action_d;
  logic              busy_q, busy_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [31:0]       word_q, word_d;
  logic [BC_W-1:0]   bcnt_q, bcnt_d;

  logic              hit_s;
  logic [SM_W-1:0]   hit_idx_s;
  logic              tag_s;
  logic [7:0]        byte_s;
  logic              u_valid_s;
  logic              u_ready_s;

`ifdef PIO_RX_UART_TAG_EN
  assign tag_s  = (bcnt_q == BC_W'(0));
  assign byte_s = tag_s ? {4'hA, 2'b00, mindex_q} : word_q[7:0];
`else
  assign tag_s  = 1'b0;
  assign byte_s = word_q[7:0];
`endif

  assign u_valid_s = (state_q == SEND) && (bcnt_q != BC_W'(NBYTES));
  assign bus_req   = bus_req_q;
  assign action    = action_q;
  assign mindex    = mindex_q;
  assign busy      = busy_q;

  // First non-empty machine at or after the scan pointer, with wrap-around.
  always_comb begin
    hit_s     = 1'b0;
    hit_idx_s = ptr_q;
    for (int i = 0; i < int'(NUM_SM); i++) begin
      if (!hit_s && !rx_empty[wrap_idx(ptr_q, i)]) begin
        hit_s     = 1'b1;
        hit_idx_s = wrap_idx(ptr_q, i);
      end else begin
        hit_s = hit_s;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    mindex_d  = mindex_q;
    bus_req_d = bus_req_q;
    action_d  = ACT_NONE;
    busy_d    = busy_q;
    lat_d     = lat_q;
    word_d    = word_q;
    bcnt_d    = bcnt_q;
    case (state_q)
      SCAN: begin
        if (hit_s) begin
          mindex_d  = hit_idx_s;
          bus_req_d = 1'b1;
          state_d   = REQ;
        end else begin
          bus_req_d = 1'b0;
        end
      end
      REQ: begin
        // Re-check emptiness every cycle so an empty FIFO is never popped.
        if (rx_empty[mindex_q]) begin
          bus_req_d = 1'b0;
          state_d   = SCAN;
        end else if (bus_gnt) begin
          action_d = PULL_ACTION;
          state_d  = ISSUE;
        end else begin
          bus_req_d = 1'b1;
        end
      end
      ISSUE: begin
        bus_req_d = 1'b0;
        busy_d    = 1'b1;
        lat_d     = LAT_W'(0);
        state_d   = WAIT;
      end
      WAIT: begin
        if (lat_q == LAT_W'(READ_LATENCY - 1)) begin
          word_d  = dout;
          bcnt_d  = BC_W'(0);
          state_d = SEND;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      SEND: begin
        if (u_valid_s && u_ready_s) begin
          bcnt_d = bcnt_q + BC_W'(1);
          word_d = tag_s ? word_q : {8'h00, word_q[31:8]};
        end else if ((bcnt_q == BC_W'(NBYTES)) && u_ready_s) begin
          busy_d  = 1'b0;
          ptr_d   = wrap_idx(mindex_q, 1);
          state_d = SCAN;
        end else begin
          bcnt_d = bcnt_q;
        end
      end
      default: begin
        state_d   = SCAN;
        bus_req_d = 1'b0;
        busy_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q   <= SCAN;
      ptr_q     <= SM_W'(0);
      mindex_q  <= SM_W'(0);
      bus_req_q <= 1'b0;
      action_q  <= ACT_NONE;
      busy_q    <= 1'b0;
      lat_q     <= LAT_W'(0);
      word_q    <= 32'h0000_0000;
      bcnt_q    <= BC_W'(0);
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      mindex_q  <= mindex_d;
      bus_req_q <= bus_req_d;
      action_q  <= action_d;
      busy_q    <= busy_d;
      lat_q     <= lat_d;
      word_q    <= word_d;
      bcnt_q    <= bcnt_d;
    end
  end

  uart_tx_8n1 #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_tx (
    .clk    (clk),
    .n_reset(n_reset),
    .valid  (u_valid_s),
    .data   (byte_s),
    .ready  (u_ready_s),
    .tx     (tx)
  );

endmodule

// File: tb/tb_pio_rx_uart.sv
// Directed bench for pio_rx_uart with CLKS_PER_BIT = 4 and a one-cycle PIO read model.
module tb_pio_rx_uart;

`ifdef PIO_RX_UART_TAG_EN
  localparam int NB = 5;
`else
  localparam int NB = 4;
`endif
  localparam int BIT = 4;

  logic        clk;
  logic        n_reset;
  logic [3:0]  rx_empty;
  logic [31:0] dout;
  logic        bus_gnt;
  logic        bus_req;
  logic [5:0]  action;
  logic [1:0]  mindex;
  logic        tx;
  logic        busy;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;
  int last_pulse_cyc = 0;
  logic [1:0]  pulse_m[$];
  logic [5:0]  pulse_a[$];
  logic [31:0] words_q[$];
  bit pend = 1'b0;

  pio_rx_uart #(
    .CLKS_PER_BIT(4),
    .READ_LATENCY(1)
  ) dut (
    .clk     (clk),
    .n_reset (n_reset),
    .rx_empty(rx_empty),
    .dout    (dout),
    .bus_gnt (bus_gnt),
    .bus_req (bus_req),
    .action  (action),
    .mindex  (mindex),
    .tx      (tx),
    .busy    (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // PIO model: the word popped by a pulse is on dout during the following cycle only.
  always @(negedge clk) begin
    if (pend && words_q.size() > 0) dout = words_q.pop_front();
    else dout = 32'hDEAD_BEEF;
    pend = (action == 6'd4);
    if (n_reset && action != 6'd0) begin
      pulse_m.push_back(mindex);
      pulse_a.push_back(action);
      last_pulse_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic wait_action(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (action === 6'd4) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_fall(input int limit, output bit ok, output int t);
    ok = 1'b0;
    t = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (tx === 1'b0) begin
        ok = 1'b1;
        t = cyc;
        break;
      end
    end
  endtask

  task automatic idle_window(input int n, input string tag);
    bit ok_tx = 1'b1;
    bit ok_req = 1'b1;
    repeat (n) begin
      @(negedge clk);
      if (tx !== 1'b1) ok_tx = 1'b0;
      if (bus_req !== 1'b0) ok_req = 1'b0;
    end
    chk({tag, "_tx_idle"}, 32'(ok_tx), 32'd1);
    chk({tag, "_no_req"}, 32'(ok_req), 32'd1);
  endtask

  task automatic rx_frame(input logic [31:0] w, input logic [1:0] m, input string tag);
    bit ok;
    int t0;
    int ferr;
    logic [7:0] got;
    logic [7:0] exp;
    wait_fall(40, ok, t0);
    chk({tag, "_tx_fall_seen"}, 32'(ok), 32'd1);
    if (ok) begin
      chk({tag, "_fall_latency"}, 32'(t0 - last_pulse_cyc), 32'd3);
      ferr = 0;
      for (int k = 0; k < NB; k++) begin
        got = 8'h00;
        for (int j = 0; j < 10; j++) begin
          wait_cyc(t0 + 10 * BIT * k + BIT * j + BIT / 2);
          if (j == 0) begin
            if (tx !== 1'b0) ferr++;
          end else if (j == 9) begin
            if (tx !== 1'b1) ferr++;
          end else begin
            got[j-1] = tx;
          end
        end
`ifdef PIO_RX_UART_TAG_EN
        exp = (k == 0) ? {4'hA, 2'b00, m} : w[8*(k-1) +: 8];
`else
        exp = w[8*k +: 8];
`endif
        chk($sformatf("%s_byte%0d", tag, k), 32'(got), 32'(exp));
      end
      chk({tag, "_framing"}, 32'(ferr), 32'd0);
      wait_cyc(t0 + 10 * BIT * NB - 1);
      chk({tag, "_busy_last_cycle"}, 32'(busy), 32'd1);
      wait_cyc(t0 + 10 * BIT * NB);
      chk({tag, "_busy_done"}, 32'(busy), 32'd0);
    end
  endtask

  initial begin
    bit ok;
    int t;
    int base;
    int ok_req;
    int ok_act;
    logic [1:0] rr_exp [5];

    n_reset = 1'b0;
    rx_empty = 4'hF;
    bus_gnt = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_action", 32'(action), 32'd0);
    chk("rst_bus_req", 32'(bus_req), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mindex", 32'(mindex), 32'd0);
    n_reset = 1'b1;
    idle_window(50, "idle_after_rst");

    // Single word from machine 1.
    words_q.push_back(32'h1234_5678);
    bus_gnt = 1'b1;
    rx_empty = 4'b1101;
    wait_action(20, ok);
    chk("t2_pulse_seen", 32'(ok), 32'd1);
    chk("t2_mindex", 32'(mindex), 32'd1);
    rx_empty = 4'hF;
    rx_frame(32'h1234_5678, 2'd1, "t2");
    chk("t2_one_pulse", 32'(pulse_m.size()), 32'd1);

    // Grant stall on machine 0.
    bus_gnt = 1'b0;
    words_q.push_back(32'hA5C3_0F96);
    rx_empty = 4'b1110;
    repeat (2) @(negedge clk);
    ok_req = 1;
    ok_act = 1;
    repeat (20) begin
      @(negedge clk);
      if (bus_req !== 1'b1) ok_req = 0;
      if (action !== 6'd0) ok_act = 0;
    end
    chk("t3_req_held", 32'(ok_req), 32'd1);
    chk("t3_no_action", 32'(ok_act), 32'd1);
    bus_gnt = 1'b1;
    @(negedge clk);
    chk("t3_pulse_after_gnt", 32'(action), 32'd4);
    chk("t3_mindex", 32'(mindex), 32'd0);
    bus_gnt = 1'b0;
    rx_empty = 4'hF;
    rx_frame(32'hA5C3_0F96, 2'd0, "t3");

    // Machine 2 empties again before the grant.
    base = pulse_m.size();
    rx_empty = 4'b1011;
    repeat (3) @(negedge clk);
    chk("t4_req_up", 32'(bus_req), 32'd1);
    chk("t4_mindex", 32'(mindex), 32'd2);
    rx_empty = 4'hF;
    @(negedge clk);
    chk("t4_req_dropped", 32'(bus_req), 32'd0);
    bus_gnt = 1'b1;
    idle_window(20, "t4");
    chk("t4_no_pulse", 32'(pulse_m.size()), 32'(base));
    chk("t4_not_busy", 32'(busy), 32'd0);

    // Reset in the middle of a frame from machine 3.
    words_q.push_back(32'h0000_0000);
    rx_empty = 4'b0111;
    wait_action(20, ok);
    chk("t1_pulse_seen", 32'(ok), 32'd1);
    rx_empty = 4'hF;
    wait_fall(20, ok, t);
    chk("t1_frame_started", 32'(ok), 32'd1);
    repeat (6) @(negedge clk);
    chk("t1_tx_low_pre_rst", 32'(tx), 32'd0);
    chk("t1_busy_pre_rst", 32'(busy), 32'd1);
    #1 n_reset = 1'b0;
    #1;
    chk("t1_rst_tx", 32'(tx), 32'd1);
    chk("t1_rst_action", 32'(action), 32'd0);
    chk("t1_rst_bus_req", 32'(bus_req), 32'd0);
    chk("t1_rst_busy", 32'(busy), 32'd0);
    chk("t1_rst_mindex", 32'(mindex), 32'd0);
    repeat (2) @(negedge clk);
    n_reset = 1'b1;
    idle_window(50, "t1_after_rst");

    // Round-robin with every FIFO non-empty; first word exercises 00/FF byte boundaries.
    base = pulse_m.size();
    words_q.push_back(32'hFFFF_0000);
    words_q.push_back(32'h89AB_CDEF);
    words_q.push_back(32'h0000_0001);
    words_q.push_back(32'h8000_0000);
    words_q.push_back(32'h5A5A_5A5A);
    rr_exp[0] = 2'd0;
    rr_exp[1] = 2'd1;
    rr_exp[2] = 2'd2;
    rr_exp[3] = 2'd3;
    rr_exp[4] = 2'd0;
    rx_empty = 4'h0;
    rx_frame(32'hFFFF_0000, 2'd0, "t6_rr0");
    rx_frame(32'h89AB_CDEF, 2'd1, "t5_rr1");
    rx_frame(32'h0000_0001, 2'd2, "t5_rr2");
    rx_frame(32'h8000_0000, 2'd3, "t5_rr3");
    rx_frame(32'h5A5A_5A5A, 2'd0, "t5_rr4");
    rx_empty = 4'hF;
    idle_window(20, "t5_end");
    chk("t5_pulse_count", 32'(pulse_m.size() - base), 32'd5);
    for (int k = 0; k < 5; k++) begin
      if (base + k < pulse_m.size()) begin
        chk($sformatf("t5_rr_mindex%0d", k), 32'(pulse_m[base+k]), 32'(rr_exp[k]));
        chk($sformatf("t5_rr_action%0d", k), 32'(pulse_a[base+k]), 32'd4);
      end else begin
        chk($sformatf("t5_rr_missing%0d", k), 32'(pulse_m.size()), 32'(base + k + 1));
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
